irq7_controller: RTL and testbench
==================================

Name: irq7_controller

Overview:
- Seven-source interrupt pending/priority controller for the single-cycle processor.
- Collapses seven request lines into one irq line to the core.
- At the core's acknowledge, returns the encoded ID of the winning source and clears its pending bit.
- Holds off further interrupts until end-of-interrupt (EOI); no nesting.

Parameters:
- NUM_SRC, 7, number of request sources; fixed at 7.
- ID_W, 3, width of the encoded source ID. Value 7 is reserved as the spurious code.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- src_req  in  7  request lines, synchronous to clk; a rising edge requests service.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  7  new mask value; 1 = source enabled.
- mask  out  7  current mask register.
- pending  out  7  current sticky pending bits.
- irq  out  1  interrupt request to the core.
- ack_req  in  1  core acknowledge pulse.
- ack_valid  out  1  one-cycle pulse, ID valid.
- ack_id  out  3  encoded source ID (0..6), or 7 for spurious.
- eoi  in  1  end-of-interrupt pulse from the core.
- busy  out  1  high while in SERVICE.

Behaviour:
- Reset (rst_n low, async): mask=7'h00, pending=0, src_prev=0, state=IDLE, irq=0, ack_valid=0, ack_id=0, busy=0.
- Edge detect: src_prev registers src_req each cycle. rise[i] = src_req[i] & ~src_prev[i].
  - The first cycle after reset, a line already high counts as a rise.
- Pending:
  - Set on rise[i], regardless of mask.
  - Cleared only by acknowledge capture.
  - If set and clear hit the same bit in the same cycle, set wins (the new edge is kept).
- Masking:
  - eff = pending & mask; irq = (state==IDLE) & (|eff).
  - irq is registered, so it is high one cycle after the pending bit sets.
  - mask_we updates mask next edge in any state; the new mask affects irq the following cycle.
- Priority: bit 0 highest, bit 6 lowest. win = lowest index set in eff.
- FSM states: IDLE, ACK, SERVICE.
  - IDLE & ack_req & |eff: latch ack_id=win, clear pending[win], go to ACK.
  - IDLE & ack_req & ~|eff: ack_id=7, go to ACK (spurious; no pending change).
  - ACK: ack_valid=1 for exactly this one cycle, ack_id held.
    - Next state is SERVICE, or IDLE if the ID was spurious.
  - SERVICE: busy=1, irq=0, ack_req ignored, pending keeps accumulating.
    - eoi: go to IDLE.
  - eoi outside SERVICE is ignored.
- Latency:
  - ack_req at edge N: ack_valid high during cycle N+1.
  - eoi at edge M: busy low and irq eligible again from cycle M+1.
- ack_id holds its last value between acknowledges.
- A source toggling repeatedly while pending stays set yields one pending event (no counting).
- Reset asserted mid-SERVICE or mid-ACK returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package (or include) holds:
  - FSM state encodings (IDLE=2'd0, ACK=2'd1, SERVICE=2'd2).
  - SPURIOUS_ID=3'd7.
  - NUM_SRC.
- One natural sub-module, prio_enc7: combinational 7-to-3 priority encoder with any-valid output.
- irq_controller instantiates prio_enc7 and holds all registers and the FSM.

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle -> irq=0, pending=0, mask=0, ack_valid=0 immediately.
- Single source:
  - Stimulus: mask=7'h7F, rise on src_req[4].
  - Expect: pending=7'h10, irq=1 next cycle. After ack_req, ack_valid pulse with ack_id=4, pending=0, busy=1, irq=0. After eoi, busy=0.
- Priority and queueing:
  - Stimulus: rises on bits 2 and 5 in the same cycle, mask=7'h7F.
  - Expect: first ack -> id 2. irq stays 0 until eoi, then irq=1. Second ack -> id 5.
- Masking:
  - Stimulus: mask=7'h01, rise on bit 3.
  - Expect: pending=7'h08, irq=0. Write mask=7'h08 -> irq=1 within 2 cycles; ack -> id 3.
- Spurious acknowledge:
  - Stimulus: ack_req with eff=0.
  - Expect: ack_valid pulse with ack_id=7, state back to IDLE, busy never high.
- Same-cycle set/clear:
  - Stimulus: bit 1 pending, a new rise on bit 1 in the same cycle as the capturing ack_req.
  - Expect: ack_id=1, pending[1] remains 1 after capture.

Source files
------------

// File: rtl/irq7_controller_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | irq7_controller_pkg : shared constants and FSM encoding for irq7_controller |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
package irq7_controller_pkg;

  localparam int NUM_SRC = 7;
  localparam int ID_W    = 3;

  // ID 7 never names a real source, so it doubles as the "nothing pending" code.
  localparam logic [ID_W-1:0] SPURIOUS_ID = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/irq7_controller_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | irq7_controller_if : request, mask and core handshake signals             |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
interface irq7_controller_if;
  import irq7_controller_pkg::*;

  logic [NUM_SRC-1:0] src_req;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               irq;
  logic               ack_req;
  logic               ack_valid;
  logic [ID_W-1:0]    ack_id;
  logic               eoi;
  logic               busy;

  // Core / source side.
  modport master (
    output src_req, mask_we, mask_wdata, ack_req, eoi,
    input  mask, pending, irq, ack_valid, ack_id, busy
  );

  // Controller side.
  modport slave (
    input  src_req, mask_we, mask_wdata, ack_req, eoi,
    output mask, pending, irq, ack_valid, ack_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/irq7_controller_prio_enc7.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | irq7_controller_prio_enc7 : 7-to-3 priority encoder, bit 0 highest          |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module irq7_controller_prio_enc7
  import irq7_controller_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    id  = '0;
    any = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = i[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq7_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | irq7_controller : seven-source pending/priority interrupt controller        |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module irq7_controller
  import irq7_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  irq7_controller_if.slave   bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_irq;
  logic [ID_W-1:0]    r_ack_id;
  logic [ID_W-1:0]    w_ack_id_nxt;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_eff;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [ID_W-1:0]    w_win;
  logic               w_any;

  localparam logic [NUM_SRC-1:0] c_one = {{(NUM_SRC-1){1'b0}}, 1'b1};

  assign w_rise = bus.src_req & ~r_src_prev;
  assign w_eff  = r_pending & r_mask;

  irq7_controller_prio_enc7 u_prio_enc7 (
    .req (w_eff),
    .id  (w_win),
    .any (w_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ack_id_nxt = r_ack_id;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ack_req) begin
          w_state_nxt = ST_ACK;
          if (w_any) begin
            w_ack_id_nxt = w_win;
            w_clr        = c_one << w_win;
          end else begin
            w_ack_id_nxt = SPURIOUS_ID;
          end
        end
      end
      ST_ACK: begin
        w_state_nxt = (r_ack_id == SPURIOUS_ID) ? ST_IDLE : ST_SERVICE;
      end
      ST_SERVICE: begin
        if (bus.eoi) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // OR-ing the rise in after the clear keeps an edge that lands on the captured bit.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_src_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_irq      <= 1'b0;
      r_ack_id   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src_prev <= bus.src_req;
      r_pending  <= w_pending_nxt;
      r_irq      <= (r_state == ST_IDLE) && w_any;
      r_ack_id   <= w_ack_id_nxt;
      if (bus.mask_we) begin
        r_mask <= bus.mask_wdata;
      end
    end
  end

  assign bus.mask      = r_mask;
  assign bus.pending   = r_pending;
  assign bus.irq       = r_irq;
  assign bus.ack_valid = (r_state == ST_ACK);
  assign bus.ack_id    = r_ack_id;
  assign bus.busy      = (r_state == ST_SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_irq7_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_irq7_controller : directed + random bench against a behavioural model    |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module tb_irq7_controller;
  import irq7_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  irq7_controller_if bus ();

  irq7_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the controller should be showing after each edge.
  bit [6:0] m_prev, m_pend, m_mask;
  bit       m_irq, m_acking, m_serving;
  bit [2:0] m_id;

  function automatic void model_reset();
    m_prev    = '0;
    m_pend    = '0;
    m_mask    = '0;
    m_irq     = 1'b0;
    m_acking  = 1'b0;
    m_serving = 1'b0;
    m_id      = '0;
  endfunction

  function automatic void model_step();
    bit [6:0] rise, eff, clr;
    bit       idle;
    int       w;
    rise = bus.src_req & ~m_prev;
    eff  = m_pend & m_mask;
    idle = !m_acking && !m_serving;
    clr  = '0;
    w    = -1;
    for (int i = 0; i < 7; i++) begin
      if (eff[i]) begin
        w = i;
        break;
      end
    end
    m_irq = idle && (eff != 0);
    if (idle && bus.ack_req) begin
      m_acking = 1'b1;
      if (w >= 0) begin
        m_id   = 3'(w);
        clr[w] = 1'b1;
      end else begin
        m_id = 3'd7;
      end
    end else if (m_acking) begin
      m_acking  = 1'b0;
      m_serving = (m_id != 3'd7);
    end else if (m_serving && bus.eoi) begin
      m_serving = 1'b0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = bus.src_req;
    if (bus.mask_we) m_mask = bus.mask_wdata;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mask",      {1'b0, bus.mask},    {1'b0, m_mask});
    chk("pending",   {1'b0, bus.pending}, {1'b0, m_pend});
    chk("irq",       {7'd0, bus.irq},       {7'd0, m_irq});
    chk("ack_valid", {7'd0, bus.ack_valid}, {7'd0, m_acking});
    chk("ack_id",    {5'd0, bus.ack_id},    {5'd0, m_id});
    chk("busy",      {7'd0, bus.busy},      {7'd0, m_serving});
  endtask

  // One clock: model and DUT advance together; single-cycle strobes drop afterwards.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.ack_req = 1'b0;
    bus.eoi     = 1'b0;
    bus.mask_we = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_irq",       {7'd0, bus.irq},       8'd0);
    chk("rst_pending",   {1'b0, bus.pending},   8'd0);
    chk("rst_mask",      {1'b0, bus.mask},      8'd0);
    chk("rst_ack_valid", {7'd0, bus.ack_valid}, 8'd0);
    chk("rst_busy",      {7'd0, bus.busy},      8'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_mask(input bit [6:0] v);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = v;
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.src_req    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack_req    = 1'b0;
    bus.eoi        = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single source on bit 4.
    write_mask(7'h7F);
    bus.src_req = 7'h10;
    step();
    chk("single_pending", {1'b0, bus.pending}, 8'h10);
    step();
    chk("single_irq", {7'd0, bus.irq}, 8'd1);
    bus.ack_req = 1'b1;
    step();
    chk("single_ack_valid", {7'd0, bus.ack_valid}, 8'd1);
    chk("single_ack_id", {5'd0, bus.ack_id}, 8'd4);
    chk("single_cleared", {1'b0, bus.pending}, 8'h00);
    step();
    chk("single_busy", {7'd0, bus.busy}, 8'd1);
    chk("single_irq_off", {7'd0, bus.irq}, 8'd0);
    bus.src_req = '0;
    bus.eoi = 1'b1;
    step();
    chk("single_eoi", {7'd0, bus.busy}, 8'd0);

    // Bits 2 and 5 together: 2 wins, 5 waits for EOI.
    bus.src_req = 7'h24;
    step();
    step();
    bus.ack_req = 1'b1;
    step();
    chk("prio_first", {5'd0, bus.ack_id}, 8'd2);
    step();
    step();
    step();
    chk("prio_hold", {7'd0, bus.irq}, 8'd0);
    bus.eoi = 1'b1;
    step();
    step();
    chk("prio_irq_again", {7'd0, bus.irq}, 8'd1);
    bus.ack_req = 1'b1;
    step();
    chk("prio_second", {5'd0, bus.ack_id}, 8'd5);
    step();
    bus.eoi = 1'b1;
    bus.src_req = '0;
    step();

    // Masked pending becomes visible after a mask write.
    write_mask(7'h01);
    bus.src_req = 7'h08;
    step();
    step();
    chk("mask_pending", {1'b0, bus.pending}, 8'h08);
    chk("mask_irq_off", {7'd0, bus.irq}, 8'd0);
    write_mask(7'h08);
    step();
    chk("mask_irq_on", {7'd0, bus.irq}, 8'd1);
    bus.ack_req = 1'b1;
    step();
    chk("mask_ack_id", {5'd0, bus.ack_id}, 8'd3);
    step();
    bus.eoi = 1'b1;
    bus.src_req = '0;
    step();

    // Spurious acknowledge.
    bus.ack_req = 1'b1;
    step();
    chk("spur_valid", {7'd0, bus.ack_valid}, 8'd1);
    chk("spur_id", {5'd0, bus.ack_id}, 8'd7);
    step();
    chk("spur_busy", {7'd0, bus.busy}, 8'd0);
    chk("spur_valid_off", {7'd0, bus.ack_valid}, 8'd0);

    // New edge on bit 1 arrives with the capturing acknowledge.
    write_mask(7'h7F);
    bus.src_req = 7'h02;
    step();
    bus.src_req = '0;
    step();
    bus.src_req = 7'h02;
    bus.ack_req = 1'b1;
    step();
    chk("setclr_id", {5'd0, bus.ack_id}, 8'd1);
    chk("setclr_pending", {1'b0, bus.pending}, 8'h02);
    step();
    async_reset();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) bus.src_req ^= 7'(1 << $urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) begin
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 7'($urandom);
      end
      bus.ack_req = ($urandom_range(0, 2) == 0);
      bus.eoi     = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
